// File: rtl/uarch_rst_seq.sv
// Staged microreset sequencer: holds the selected core domains in reset while the flush
// controller requests it, then releases them one by one in ascending order with a stagger gap.
module uarch_rst_seq #(
   parameter int unsigned NUM_DOMAINS = 4,
   parameter int unsigned STAGGER_W   = 4,
   parameter int unsigned ASSERT_MIN  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   rst_uarch_ni,
   input  logic [NUM_DOMAINS-1:0] dom_mask_i,
   input  logic [STAGGER_W-1:0]   stagger_i,
   output logic [NUM_DOMAINS-1:0] rst_dom_no,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [15:0]            seq_cycles_o
);

   localparam int unsigned HoldW = (ASSERT_MIN < 1) ? 1 : $clog2(ASSERT_MIN + 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StHold    = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [NUM_DOMAINS-1:0] mask_q, mask_d;
   logic [NUM_DOMAINS-1:0] pending_q, pending_d;
   logic [STAGGER_W-1:0]   stag_q, stag_d;
   logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [STAGGER_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [15:0]            seq_q, seq_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [NUM_DOMAINS-1:0] lowest;
   logic [15:0]            seq_inc;
   logic                   hold_met;
   logic                   start;

   // Isolate the lowest set bit of the pending mask.
   assign lowest   = pending_q & (~pending_q + NUM_DOMAINS'(1));
   assign seq_inc  = (seq_q == 16'hFFFF) ? seq_q : seq_q + 16'd1;
   assign hold_met = (hold_cnt_q >= HoldW'(ASSERT_MIN));
   assign start    = ((state_q == StIdle) || (state_q == StDone)) && !rst_uarch_ni;

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      pending_d  = pending_q;
      stag_d     = stag_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      seq_d      = seq_q;
      dom_d      = dom_q;
      done_d     = 1'b0;

      case (state_q)
         StIdle: begin
         end
         StHold: begin
            seq_d = seq_inc;
            if (!hold_met) begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
            if (rst_uarch_ni && hold_met) begin
               state_d   = StRelease;
               gap_cnt_d = '0;
            end
         end
         StRelease: begin
            seq_d = seq_inc;
            if (!rst_uarch_ni) begin
               // Retrigger: restart the hold with the mask latched at sequence start.
               state_d    = StHold;
               pending_d  = mask_q;
               dom_d      = ~mask_q;
               hold_cnt_d = HoldW'(1);
            end else if (pending_q == '0) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else if (gap_cnt_q == '0) begin
               dom_d     = dom_q | lowest;
               pending_d = pending_q & ~lowest;
               gap_cnt_d = stag_q;
               if ((pending_q & ~lowest) == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - STAGGER_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (start) begin
         state_d    = StHold;
         mask_d     = dom_mask_i;
         pending_d  = dom_mask_i;
         stag_d     = stagger_i;
         dom_d      = ~dom_mask_i;
         hold_cnt_d = HoldW'(1);
         seq_d      = 16'd1;
      end
   end

   assign busy_d = (state_d != StIdle);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         mask_q     <= '0;
         pending_q  <= '0;
         stag_q     <= '0;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         seq_q      <= '0;
         dom_q      <= '1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         pending_q  <= pending_d;
         stag_q     <= stag_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         seq_q      <= seq_d;
         dom_q      <= dom_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rst_dom_no   = dom_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign seq_cycles_o = seq_q;

endmodule

// File: doc/uarch_rst_seq.md
# uarch_rst_seq

Staged microarchitectural reset sequencer that sits directly downstream of the flush controller. It consumes the controller's active-low microreset level `rst_uarch_ni`. While that level is low it holds a configurable set of core reset domains in reset. When the level is released, it deasserts the domains one at a time, in ascending index order, with a programmable stagger between releases. This avoids simultaneous release of all domains and the resulting current surge and cross-domain handshake hazards. It reports completion with a one-cycle done pulse and a cycle-count statistic.

## Interface
- `NUM_DOMAINS`, default 4: number of reset domains.
- `STAGGER_W`, default 4: width of the stagger configuration.
- `ASSERT_MIN`, default 2: minimum number of cycles any domain stays in reset (≥1).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `rst_uarch_ni`  in  1  microreset request from the flush controller, active-low level, synchronous to `clk_i`.
- `dom_mask_i`  in  NUM_DOMAINS  participating domains; latched at sequence start.
- `stagger_i`  in  STAGGER_W  gap between releases minus one; latched at sequence start.
- `rst_dom_no`  out  NUM_DOMAINS  per-domain microreset, active-low, registered.
- `busy_o`  out  1  sequencer not in IDLE.
- `done_o`  out  1  one-cycle pulse at sequence completion.
- `seq_cycles_o`  out  16  length in cycles of the last sequence, saturating.

## Operation
- States: IDLE, HOLD, RELEASE, DONE.
- All outputs are registered.
- Reset values:
  - `rst_dom_no` = all ones.
  - `busy_o` = 0.
  - `done_o` = 0.
  - `seq_cycles_o` = 0.
  - State = IDLE.
  - Internal pending mask, hold counter and gap counter = 0.
- IDLE:
  - When `rst_uarch_ni` is sampled 0, go to HOLD.
  - Latch `dom_mask_i` into `pending` and `stagger_i` into `stag_q`.
  - Clear the domain bits of `pending` (rst_dom_no = ~pending).
  - Set `hold_cnt` = 1 and load `seq_cycles` = 1.
- HOLD:
  - `hold_cnt` increments each cycle, saturating at ASSERT_MIN.
  - Go to RELEASE when `rst_uarch_ni` == 1 and `hold_cnt` >= ASSERT_MIN; set `gap_cnt` = 0 on entry.
- RELEASE:
  - If `rst_uarch_ni` == 0: go to HOLD, reassert every latched-mask domain, set `hold_cnt` = 1. The sequence restarts and `seq_cycles` keeps counting.
  - Else if `gap_cnt` == 0: deassert the lowest-index bit in `pending`, clear that bit, and load `gap_cnt` = `stag_q`.
  - Else decrement `gap_cnt`.
  - Go to DONE on the edge that clears the last pending bit.
  - If `pending` is empty on entry (mask 0), go to DONE on the first RELEASE edge.
- DONE:
  - `done_o` = 1 for exactly this cycle.
  - Next state is IDLE, unless `rst_uarch_ni` == 0, in which case go to HOLD and restart with a fresh latch of mask and stagger.
- `seq_cycles`:
  - Increments, saturating at 16'hFFFF, on every edge where the current state is HOLD or RELEASE.
  - Holds its value in DONE and IDLE.
  - Reports the total number of non-IDLE cycles, including the DONE cycle.
- `busy_o` = 1 in HOLD, RELEASE and DONE.
- Domains outside the latched mask never leave 1.
- Changes to `dom_mask_i` or `stagger_i` after the sequence has started are ignored.
- `rst_ni` asserted mid-sequence: everything returns to reset values immediately (asynchronously), and all `rst_dom_no` are forced to 1. The global reset covers those domains.

## Timing
- Let edge k be the first edge that samples `rst_uarch_ni` = 0. Masked domains go low in the cycle after edge k.
- Let edge r be the first edge in HOLD that satisfies the exit condition.
- The first masked domain goes high after edge r+1.
- Each subsequent masked domain goes high `stag_q`+1 cycles after the previous one.
- `done_o` coincides with the cycle in which the last domain goes high.
- Every masked domain stays low for at least ASSERT_MIN+1 cycles.
- Release is gated only by `rst_uarch_ni` and `hold_cnt`. There is no dependency on external acknowledgements.

## Test plan
- Reset: drive `rst_ni` low mid-RELEASE → `rst_dom_no` = 4'hF, `busy_o` = 0, `done_o` = 0, `seq_cycles_o` = 0 immediately.
- mask 4'hF, stagger 0, `rst_uarch_ni` low for 16 cycles (sampled low at edges 1–16, high at edge 17):
  - All domains low after edge 1.
  - Domains 0, 1, 2, 3 go high after edges 18, 19, 20, 21 respectively.
  - `done_o` high only in the cycle after edge 21.
  - `seq_cycles_o` = 21.
- mask 4'b1010, stagger 3, same request: domain 1 goes high after edge 18 and domain 3 after edge 22. Domains 0 and 2 stay 1 throughout. `done_o` pulses once.
- Single-cycle request (low at edge 1 only), ASSERT_MIN 2, mask 4'h1: domain 0 is low in the cycles after edges 1–3 and goes high after edge 4.
- Retrigger: with stagger 2, pull `rst_uarch_ni` low one cycle after domain 0 releases → domain 0 reasserts on the next cycle. The sequence restarts and produces exactly one `done_o` pulse at the end.
- mask 0, 16-cycle request: `rst_dom_no` stays 4'hF. `done_o` pulses after edge 18. `busy_o` = 1 from edge 1 through that DONE cycle.
